// File: rtl/vga_timing_pkg.sv
// Shared constants for the 640x480@60 raster generator.
// Defaults describe the standard VGA mode; the top exposes them as parameters.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned H_VIS   = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned H_SYNC_START = H_VIS + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

    localparam int unsigned V_VIS   = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned V_SYNC_START = V_VIS + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // Drive level of a sync line given whether the raster is inside the pulse.
    function automatic logic sync_level(logic in_sync, logic pol);
        return in_sync ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts enabled steps 0..TOTAL-1, flags the wrap step and
// decodes sync/visible windows from the value the counter is about to take,
// so registered decodes line up with the registered count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_END   = 751,
    parameter int unsigned VIS        = 640
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               in_sync,
    output logic               in_vis
);

    localparam logic [COORD_W-1:0] LAST  = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] SS    = COORD_W'(SYNC_START);
    localparam logic [COORD_W-1:0] SE    = COORD_W'(SYNC_END);
    localparam logic [COORD_W-1:0] VIS_C = COORD_W'(VIS);

    logic [COORD_W-1:0] count_q, count_d;

    // Next count; >= LAST also recovers from any out-of-range value.
    always_comb begin
        wrap    = en && (count_q >= LAST);
        count_d = count_q;
        if (en) begin
            count_d = wrap ? '0 : count_q + COORD_W'(1);
        end
        in_sync = (count_d >= SS) && (count_d <= SE);
        in_vis  = (count_d < VIS_C);
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, H/V counters, registered syncs.
// Optional macro VGA_FRAME_CNT_EN adds a 16-bit completed-frame counter port.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned HVIS     = H_VIS,
    parameter int unsigned HFP      = H_FP,
    parameter int unsigned HSYNC    = H_SYNC,
    parameter int unsigned HBP      = H_BP,
    parameter int unsigned VVIS     = V_VIS,
    parameter int unsigned VFP      = V_FP,
    parameter int unsigned VSYNC    = V_SYNC,
    parameter int unsigned VBP      = V_BP
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pix_tick,
    output logic [COORD_W-1:0] Xcoordinate,
    output logic [COORD_W-1:0] Ycoordinate,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic               line_end,
`ifdef VGA_FRAME_CNT_EN
    output logic               frame_start,
    output logic [15:0]        frame_cnt
`else
    output logic               frame_start
`endif
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_tick_q;
    logic             hsync_q, vsync_q, active_q, frame_start_q;
    logic             h_wrap, h_in_sync, h_in_vis;
    logic             v_wrap, v_in_sync, v_in_vis;

    vga_axis_counter #(
        .TOTAL      (HVIS + HFP + HSYNC + HBP),
        .SYNC_START (HVIS + HFP),
        .SYNC_END   (HVIS + HFP + HSYNC - 1),
        .VIS        (HVIS)
    ) u_h (
        .clk     (clk),
        .reset   (reset),
        .en      (pix_tick_q),
        .count   (Xcoordinate),
        .wrap    (h_wrap),
        .in_sync (h_in_sync),
        .in_vis  (h_in_vis)
    );

    vga_axis_counter #(
        .TOTAL      (VVIS + VFP + VSYNC + VBP),
        .SYNC_START (VVIS + VFP),
        .SYNC_END   (VVIS + VFP + VSYNC - 1),
        .VIS        (VVIS)
    ) u_v (
        .clk     (clk),
        .reset   (reset),
        .en      (h_wrap),
        .count   (Ycoordinate),
        .wrap    (v_wrap),
        .in_sync (v_in_sync),
        .in_vis  (v_in_vis)
    );

    // Divider next state; with CLK_DIV=1 it stays at 0 and pix_tick stays high.
    always_comb begin
        div_d = (div_q >= DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    // Divider, pixel enable and coordinate-aligned output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            pix_tick_q    <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            active_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_tick_q    <= (div_q == DIV_LAST);
            hsync_q       <= sync_level(h_in_sync, SYNC_POL);
            vsync_q       <= sync_level(v_in_sync, SYNC_POL);
            active_q      <= h_in_vis && v_in_vis;
            // v_wrap implies h_wrap: this edge takes (last,last) to (0,0).
            frame_start_q <= v_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Completed-frame counter, stepped by each frame_start pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (frame_start_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign pix_tick    = pix_tick_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign line_end    = h_wrap;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (23x10 pixels, CLK_DIV=3) so that
// several whole frames fit in a short run. Outputs are predicted from the count of
// non-reset clock edges since the last reset.
module tb_vga_timing_gen;

    localparam int unsigned D   = 3;
    localparam bit          POL = 1'b0;
    localparam int unsigned HV = 16, HF = 2, HS = 3, HB = 2;
    localparam int unsigned VV = 6,  VF = 1, VS = 2, VB = 1;
    localparam int unsigned HT = HV + HF + HS + HB;
    localparam int unsigned VT = VV + VF + VS + VB;
    localparam int unsigned FT = HT * VT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_tick, hsync, vsync, active, line_end, frame_start;
    logic [9:0] x, y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    vga_timing_gen #(
        .CLK_DIV  (D),
        .SYNC_POL (POL),
        .HVIS     (HV),
        .HFP      (HF),
        .HSYNC    (HS),
        .HBP      (HB),
        .VVIS     (VV),
        .VFP      (VF),
        .VSYNC    (VS),
        .VBP      (VB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_tick    (pix_tick),
        .Xcoordinate (x),
        .Ycoordinate (y),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .line_end    (line_end),
`ifdef VGA_FRAME_CNT_EN
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
`else
        .frame_start (frame_start)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: non-reset edges since the last reset edge.
    int n = 0;
    bit started = 1'b0;
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            n       <= 0;
            started <= 1'b1;
        end else begin
            n <= n + 1;
        end
    end

    // Pixels stepped after k edges: the first pix_tick is seen after edge D,
    // so the edge after it is the first to advance.
    function automatic int pix(input int k);
        return (k == 0) ? 0 : (k - 1) / D;
    endfunction

    // Per-cycle comparison of every output against the arithmetic model.
    always @(negedge clk) begin
        if (started) begin
            int p, ex, ey;
            logic pt, hs, vs, act, le, fs;
            p   = pix(n);
            ex  = p % HT;
            ey  = (p / HT) % VT;
            pt  = (n >= 1) && (n % D == 0);
            hs  = (ex >= HV + HF && ex < HV + HF + HS) ? POL : ~POL;
            vs  = (ey >= VV + VF && ey < VV + VF + VS) ? POL : ~POL;
            act = (ex < HV) && (ey < VV);
            le  = pt && (ex == HT - 1);
            fs  = (n >= 2) && (pix(n) != pix(n - 1)) && (pix(n) % FT == 0);
            check("outputs {pt,x,y,hs,vs,act,le,fs}",
                  {6'd0, pix_tick, x, y, hsync, vsync, active, line_end, frame_start},
                  {6'd0, pt, 10'(ex), 10'(ey), hs, vs, act, le, fs});
`ifdef VGA_FRAME_CNT_EN
            check("frame_cnt", {16'd0, frame_cnt},
                  (n >= 1) ? 32'((pix(n - 1) / FT) % 65536) : 32'd0);
`endif
        end
    end

    // Pulse-width and period measurement during the reset-free window.
    bit meas_en = 1'b0;
    int hs_run = 0, hs_last = 0, vs_run = 0, vs_last = 0;
    int fs_count = 0, fs_prev = -1, fs_period = 0;

    always @(negedge clk) begin
        if (meas_en) begin
            if (hsync == POL) hs_run++;
            else if (hs_run > 0) begin hs_last = hs_run; hs_run = 0; end
            if (vsync == POL) vs_run++;
            else if (vs_run > 0) begin vs_last = vs_run; vs_run = 0; end
            if (frame_start) begin
                fs_count++;
                if (fs_prev >= 0) fs_period = cyc - fs_prev;
                fs_prev = cyc;
            end
        end
    end

    int rst_left = 0;

    initial begin
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state, before any non-reset edge.
        @(negedge clk);
        check("reset x", {22'd0, x}, 32'd0);
        check("reset y", {22'd0, y}, 32'd0);
        check("reset active", {31'd0, active}, 32'd1);
        check("reset hsync", {31'd0, hsync}, 32'd1);
        check("reset vsync", {31'd0, vsync}, 32'd1);
        check("reset pix_tick", {31'd0, pix_tick}, 32'd0);
        check("reset frame_start", {31'd0, frame_start}, 32'd0);

        // First pix_tick after the third edge, X advances on the next.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("first pix_tick", {31'd0, pix_tick}, 32'd1);
        check("x before step", {22'd0, x}, 32'd0);
        @(negedge clk);
        check("x after step", {22'd0, x}, 32'd1);
        check("pix_tick drop", {31'd0, pix_tick}, 32'd0);

        // Three whole frames without reset: 23*10*3 = 690 clk per frame.
        meas_en = 1'b1;
        repeat (3 * 690 + 100) @(negedge clk);
        meas_en = 1'b0;
        check("hsync low width clk", 32'(hs_last), 32'd9);
        check("vsync low width clk", 32'(vs_last), 32'd138);
        check("frame_start period clk", 32'(fs_period), 32'd690);
        check("frame_start pulses", 32'(fs_count), 32'd3);
`ifdef VGA_FRAME_CNT_EN
        check("frame_cnt after 3 frames", {16'd0, frame_cnt}, 32'd3);
`endif

        // Random short resets over a long run; the per-cycle model follows.
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (rst_left > 0) rst_left--;
                if (rst_left == 0) reset = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                reset    = 1'b1;
                rst_left = $urandom_range(0, 2);
            end
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
